// File: rtl/pq_order_tally.sv
`default_nettype none
// ============================================================================
// Module   : pq_order_tally
// Purpose  : Session-level tally for the priority-queue order comparator.
//            A drain session opens on 'start'. It closes on the comparator
//            sentinel, on queue empty, or on an optional idle watchdog. The
//            block then reports the sample count, a saturating violation
//            count and a registered pass/fail result.
// Ports    : clk, rst (async, active-high)
//            start     - session start pulse, ignored while busy
//            enb       - dequeue enable shared with the comparator
//            empty     - queue empty flag shared with the comparator
//            verdict   - comparator oldVal > newVal, valid the cycle after enb
//            cteal_15  - comparator sentinel flag, valid in the enb cycle
//            busy/done/pass/timeout - session status (all registered)
//            err_count - saturating order-violation count (ERR_W bits)
//            smp_count - saturating accepted-sample count (SMP_W bits)
// Options  : PQ_TALLY_TIMEOUT_EN enables the idle watchdog (TIMEOUT cycles).
// Revision : 1.0 - initial release
// ============================================================================
module pq_order_tally #(
    parameter int ERR_W   = 8,
    parameter int SMP_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             enb,
    input  logic             empty,
    input  logic             verdict,
    input  logic             cteal_15,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_count,
    output logic [SMP_W-1:0] smp_count
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic             r_enb_d;
    logic             r_end_seen;
    logic             w_start_ok;
    logic             w_acc;
    logic             w_sentinel;
    logic             w_chk;
    logic             w_err_inc;
    logic [ERR_W-1:0] w_err_nx;
    logic             w_wd_fire;
    logic             w_done_entry;

    // A start is only honoured between sessions.
    assign w_start_ok = start & ((r_state == c_st_idle) | (r_state == c_st_done));

    // Samples are accepted only while running.
    assign w_acc      = enb & (r_state == c_st_run);

    // Only the first sentinel of a session terminates it.
    assign w_sentinel = w_acc & cteal_15 & ~r_end_seen;

    // The comparator's old value is stale for the first sample of a session.
    // Its verdict is therefore ignored. By the enb_d cycle of sample N,
    // smp_count already includes sample N, so ">= 2" skips only the first.
    assign w_chk      = r_enb_d & (smp_count >= SMP_W'(2));
    assign w_err_inc  = w_chk & verdict & ~(&err_count);
    assign w_err_nx   = err_count + {{(ERR_W-1){1'b0}}, w_err_inc};

    assign w_done_entry = (w_state_nx == c_st_done) & (r_state != c_st_done);

`ifdef PQ_TALLY_TIMEOUT_EN
    localparam int c_idle_w = $clog2(TIMEOUT + 1);

    logic [c_idle_w-1:0] r_idle;

    // Counts consecutive RUN cycles without enb. It fires on the TIMEOUT-th
    // idle cycle, so DONE is entered on that cycle's closing edge.
    assign w_wd_fire = (r_state == c_st_run) & ~enb &
                       (r_idle == c_idle_w'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_start_ok || enb || (r_state != c_st_run)) begin
            r_idle <= '0;
        end else if (!w_wd_fire) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    // No watchdog in this build. TIMEOUT is kept only so the parameter list
    // matches the watchdog build; the term folds to a constant 0.
    assign w_wd_fire = 1'b0 & (TIMEOUT > 0);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nx = c_st_run;
                end
            end
            c_st_run: begin
                // enb wins over empty in the same cycle. A normal empty
                // termination takes priority over a coincident watchdog expiry.
                if (w_sentinel) begin
                    w_state_nx = c_st_flush;
                end else if (empty && !enb) begin
                    w_state_nx = c_st_flush;
                end else if (w_wd_fire) begin
                    w_state_nx = c_st_done;
                end
            end
            c_st_flush: begin
                w_state_nx = c_st_done;
            end
            default: begin
                w_state_nx = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_enb_d    <= 1'b0;
            r_end_seen <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            err_count  <= '0;
            smp_count  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_enb_d <= w_acc;
            busy    <= (w_state_nx == c_st_run) | (w_state_nx == c_st_flush);

            if (w_start_ok) begin
                r_end_seen <= 1'b0;
                done       <= 1'b0;
                pass       <= 1'b0;
                timeout    <= 1'b0;
                err_count  <= '0;
                smp_count  <= '0;
            end else begin
                err_count <= w_err_nx;
                if (w_acc && !(&smp_count)) begin
                    smp_count <= smp_count + 1'b1;
                end
                if (w_sentinel) begin
                    r_end_seen <= 1'b1;
                end
                // The result uses the post-update error count. The verdict
                // checked in FLUSH therefore counts toward pass.
                if (w_done_entry) begin
                    done    <= 1'b1;
                    pass    <= (w_err_nx == '0) & ~w_wd_fire;
                    timeout <= w_wd_fire;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pq_order_tally.sv
`default_nettype none
// ============================================================================
// Module   : tb_pq_order_tally
// Purpose  : Directed self-checking bench for pq_order_tally. Two instances
//            share one stimulus stream: the default widths, and ERR_W = 2 for
//            saturation. Expected values are hand-derived from the
//            comparator behaviour oldVal > newVal.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pq_order_tally;

    localparam int c_tmo = 8;

    logic        clk;
    logic        rst;
    logic        start;
    logic        enb;
    logic        empty;
    logic        verdict;
    logic        cteal_15;

    logic        busy, done, pass, timeout;
    logic [7:0]  err_count;
    logic [15:0] smp_count;

    logic        s_busy, s_done, s_pass, s_timeout;
    logic [1:0]  s_err_count;
    logic [15:0] s_smp_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] seq [0:15];
    int         seq_n;

    pq_order_tally #(.ERR_W(8), .SMP_W(16), .TIMEOUT(c_tmo)) u_dut (
        .clk(clk), .rst(rst), .start(start), .enb(enb), .empty(empty),
        .verdict(verdict), .cteal_15(cteal_15),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .smp_count(smp_count)
    );

    pq_order_tally #(.ERR_W(2), .SMP_W(16), .TIMEOUT(c_tmo)) u_sat (
        .clk(clk), .rst(rst), .start(start), .enb(enb), .empty(empty),
        .verdict(verdict), .cteal_15(cteal_15),
        .busy(s_busy), .done(s_done), .pass(s_pass), .timeout(s_timeout),
        .err_count(s_err_count), .smp_count(s_smp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives seq[0..seq_n-1] one per cycle, with the comparator verdict for
    // the previous sample. It then runs the FLUSH cycle, where the last
    // verdict is driven. It returns in the first DONE cycle.
    task automatic drain();
        logic [7:0] prev;
        logic       vnext;
        prev  = 8'h00;
        vnext = 1'b0;
        for (int i = 0; i < seq_n; i++) begin
            enb      = 1'b1;
            cteal_15 = (seq[i] == 8'hFE);
            verdict  = vnext;
            vnext    = (prev > seq[i]);
            prev     = seq[i];
            tick();
        end
        enb      = 1'b0;
        cteal_15 = 1'b0;
        verdict  = vnext;
        check("flush_busy", {31'b0, busy}, 32'd1);
        check("flush_notdone", {31'b0, done}, 32'd0);
        tick();
        verdict = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; enb = 1'b0; empty = 1'b0;
        verdict = 1'b0; cteal_15 = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_pass", {31'b0, pass}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_err", {24'b0, err_count}, 32'd0);
        check("rst_smp", {16'b0, smp_count}, 32'd0);
        rst = 1'b0;
        tick();

        // Ordered drain 1,3,3,7,FE
        pulse_start();
        check("t1_busy", {31'b0, busy}, 32'd1);
        seq[0] = 8'h01; seq[1] = 8'h03; seq[2] = 8'h03; seq[3] = 8'h07; seq[4] = 8'hFE;
        seq_n = 5;
        drain();
        check("t1_done", {31'b0, done}, 32'd1);
        check("t1_pass", {31'b0, pass}, 32'd1);
        check("t1_busy_off", {31'b0, busy}, 32'd0);
        check("t1_smp", {16'b0, smp_count}, 32'd5);
        check("t1_err", {24'b0, err_count}, 32'd0);
        check("t1_timeout", {31'b0, timeout}, 32'd0);

        // Violations 9,4,6,2,FE
        pulse_start();
        check("t2_done_clr", {31'b0, done}, 32'd0);
        seq[0] = 8'h09; seq[1] = 8'h04; seq[2] = 8'h06; seq[3] = 8'h02; seq[4] = 8'hFE;
        seq_n = 5;
        drain();
        check("t2_done", {31'b0, done}, 32'd1);
        check("t2_err", {24'b0, err_count}, 32'd2);
        check("t2_pass", {31'b0, pass}, 32'd0);
        check("t2_smp", {16'b0, smp_count}, 32'd5);

        // First-sample mask and empty termination. The enb coinciding with
        // start is not accepted.
        start = 1'b1; enb = 1'b1;
        tick();
        start = 1'b0; enb = 1'b1;
        tick();
        enb = 1'b0; verdict = 1'b1;
        tick();
        verdict = 1'b0; empty = 1'b1;
        tick();
        empty = 1'b0;
        check("t3_flush_busy", {31'b0, busy}, 32'd1);
        tick();
        check("t3_done", {31'b0, done}, 32'd1);
        check("t3_err", {24'b0, err_count}, 32'd0);
        check("t3_smp", {16'b0, smp_count}, 32'd1);
        check("t3_pass", {31'b0, pass}, 32'd1);

        // Saturation: 6 violations
        pulse_start();
        seq[0] = 8'h70; seq[1] = 8'h60; seq[2] = 8'h50; seq[3] = 8'h40;
        seq[4] = 8'h30; seq[5] = 8'h20; seq[6] = 8'h10; seq[7] = 8'hFE;
        seq_n = 8;
        drain();
        check("t4_err_wide", {24'b0, err_count}, 32'd6);
        check("t4_err_sat", {30'b0, s_err_count}, 32'd3);
        check("t4_pass_sat", {31'b0, s_pass}, 32'd0);
        check("t4_done_sat", {31'b0, s_done}, 32'd1);
        check("t4_smp", {16'b0, smp_count}, 32'd8);

        // enb wins over empty, start ignored while busy, then async reset
        pulse_start();
        enb = 1'b1; empty = 1'b1;
        tick();
        empty = 1'b0;
        check("t5_enb_wins", {31'b0, busy}, 32'd1);
        tick();
        start = 1'b1; verdict = 1'b1;
        tick();
        start = 1'b0; enb = 1'b0; verdict = 1'b1;
        check("t5_smp3", {16'b0, smp_count}, 32'd3);
        check("t5_err1", {24'b0, err_count}, 32'd1);
        tick();
        verdict = 1'b0;
        check("t5_err2", {24'b0, err_count}, 32'd2);
        check("t5_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_busy", {31'b0, busy}, 32'd0);
        check("t5_rst_err", {24'b0, err_count}, 32'd0);
        check("t5_rst_smp", {16'b0, smp_count}, 32'd0);
        check("t5_rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        tick();
        pulse_start();
        seq[0] = 8'h02; seq[1] = 8'hFE;
        seq_n = 2;
        drain();
        check("t5_re_done", {31'b0, done}, 32'd1);
        check("t5_re_pass", {31'b0, pass}, 32'd1);
        check("t5_re_smp", {16'b0, smp_count}, 32'd2);

        // Watchdog
        pulse_start();
        enb = 1'b1;
        tick();
        enb = 1'b0; empty = 1'b0;
        repeat (c_tmo - 1) tick();
        check("t6_busy_pre", {31'b0, busy}, 32'd1);
        tick();
`ifdef PQ_TALLY_TIMEOUT_EN
        check("t6_done", {31'b0, done}, 32'd1);
        check("t6_timeout", {31'b0, timeout}, 32'd1);
        check("t6_pass", {31'b0, pass}, 32'd0);
        check("t6_busy_off", {31'b0, busy}, 32'd0);
`else
        repeat (100 - c_tmo) tick();
        check("t6_still_busy", {31'b0, busy}, 32'd1);
        check("t6_no_done", {31'b0, done}, 32'd0);
        check("t6_no_timeout", {31'b0, timeout}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
